pq_arb: RTL and testbench

Round-robin scheduler that shares one register-array priority queue among NREQ requesters. It accepts enqueue, dequeue and replace requests, grants one at a time, and drives the PQ command strobes. It holds off the PQ for a programmable settle time and returns the pre-operation head key/value to the granted requester. It sits between the client logic and the PQ, and is the only driver of the PQ command inputs.

---
 rtl/pq_arb.sv | 255 +++++++++++++++++++++++++
 tb/tb_pq_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_arb.sv
// pq_arb: round-robin scheduler that shares one priority queue among NREQ requesters.
// Optional statistics counters are built only when PQ_ARB_STATS_EN is defined.
package pq_pkg;
    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;
endpackage

module pq_arb #(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 1,
    parameter int KW         = pq_pkg::KEY_WIDTH,
    parameter int VW         = pq_pkg::VAL_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*2-1:0]         req_op,
    input  logic [NREQ*(KW+VW)-1:0]   req_kv,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [KW+VW-1:0]          rsp_kv,
    output logic [KW+VW-1:0]          pq_kvi,
    output logic                      pq_enq,
    output logic                      pq_deq,
    output logic                      pq_replace,
    input  logic [KW+VW-1:0]          pq_kvo,
    input  logic                      pq_empty,
    input  logic                      pq_full,
    output logic [15:0]               stat_ops,
    output logic [15:0]               stat_blk
);
    localparam int IDW = $clog2(NREQ);
    localparam int KVW = KW + VW;
    localparam logic [1:0] OP_ENQ = 2'b01;
    localparam logic [1:0] OP_DEQ = 2'b10;
    localparam logic [1:0] OP_REP = 2'b11;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [IDW-1:0]     id_r, id_s;
    logic [1:0]         op_r, op_s;
    logic [3:0]         cnt_r, cnt_s;
    logic [IDW-1:0]     last_r, last_s;
    logic               pq_enq_r, pq_enq_s;
    logic               pq_deq_r, pq_deq_s;
    logic               pq_rep_r, pq_rep_s;
    logic [KVW-1:0]     pq_kvi_r, pq_kvi_s;
    logic [NREQ-1:0]    req_ready_r, req_ready_s;
    logic               rsp_valid_r, rsp_valid_s;
    logic [IDW-1:0]     rsp_id_r, rsp_id_s;
    logic [KVW-1:0]     rsp_kv_r, rsp_kv_s;
    logic               enter_resp_s;

    logic [NREQ-1:0]    elig_s;
    logic               grant_found_s;
    logic [IDW-1:0]     grant_id_s;
    logic [NREQ-1:0]    grant_oh_s;
    logic [1:0]         grant_op_s;
    logic [KVW-1:0]     grant_kv_s;
    int                 best_off_s;
    int                 off_s;

    function automatic logic op_eligible(input logic valid, input logic [1:0] op,
                                         input logic empty, input logic full);
        logic ok;
        case (op)
            OP_ENQ:         ok = valid & ~full;
            OP_DEQ, OP_REP: ok = valid & ~empty;
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Per-requester eligibility against the PQ status seen this cycle.
    always_comb begin
        elig_s = '0;
        for (int r = 0; r < NREQ; r++) begin
            elig_s[r] = op_eligible(req_valid[r], req_op[2*r +: 2], pq_empty, pq_full);
        end
    end

    // Round-robin pick: smallest distance after the last grant wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        grant_oh_s    = '0;
        grant_op_s    = 2'b00;
        grant_kv_s    = '0;
        best_off_s    = NREQ;
        off_s         = 0;
        for (int r = 0; r < NREQ; r++) begin
            off_s = (r + NREQ - 1 - int'(last_r)) % NREQ;
            if (elig_s[r] && (off_s < best_off_s)) begin
                best_off_s    = off_s;
                grant_found_s = 1'b1;
                grant_id_s    = IDW'(r);
                grant_oh_s    = '0;
                grant_oh_s[r] = 1'b1;
                grant_op_s    = req_op[2*r +: 2];
                grant_kv_s    = req_kv[KVW*r +: KVW];
            end else begin
                best_off_s = best_off_s;
            end
        end
    end

    // Next-state and next-output logic; strobes are pulses so they default low.
    always_comb begin
        state_s      = state_r;
        id_s         = id_r;
        op_s         = op_r;
        cnt_s        = cnt_r;
        last_s       = last_r;
        pq_enq_s     = 1'b0;
        pq_deq_s     = 1'b0;
        pq_rep_s     = 1'b0;
        pq_kvi_s     = pq_kvi_r;
        req_ready_s  = '0;
        rsp_valid_s  = 1'b0;
        rsp_id_s     = rsp_id_r;
        rsp_kv_s     = rsp_kv_r;
        enter_resp_s = 1'b0;
        case (state_r)
            ARB: begin
                if (grant_found_s) begin
                    state_s     = ISSUE;
                    id_s        = grant_id_s;
                    op_s        = grant_op_s;
                    pq_kvi_s    = grant_kv_s;
                    req_ready_s = grant_oh_s;
                    pq_enq_s    = (grant_op_s == OP_ENQ);
                    pq_deq_s    = (grant_op_s == OP_DEQ);
                    pq_rep_s    = (grant_op_s == OP_REP);
                end else begin
                    state_s = ARB;
                end
            end
            ISSUE: begin
                if (op_r != OP_ENQ) begin
                    rsp_kv_s = pq_kvo;
                end else begin
                    rsp_kv_s = rsp_kv_r;
                end
                cnt_s = 4'(SETTLE_CYC);
                // The ISSUE cycle already covers one settle cycle.
                if (SETTLE_CYC <= 1) begin
                    enter_resp_s = 1'b1;
                end else begin
                    state_s = SETTLE;
                end
            end
            SETTLE: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd2) begin
                    enter_resp_s = 1'b1;
                end else begin
                    state_s = SETTLE;
                end
            end
            RESP: begin
                last_s  = id_r;
                state_s = ARB;
            end
            default: begin
                state_s = ARB;
            end
        endcase
        if (enter_resp_s) begin
            state_s     = RESP;
            rsp_valid_s = (op_r != OP_ENQ);
            rsp_id_s    = (op_r != OP_ENQ) ? id_r : rsp_id_r;
        end else begin
            rsp_valid_s = rsp_valid_s;
        end
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ARB;
            id_r        <= '0;
            op_r        <= 2'b00;
            cnt_r       <= 4'd0;
            last_r      <= IDW'(NREQ - 1);
            pq_enq_r    <= 1'b0;
            pq_deq_r    <= 1'b0;
            pq_rep_r    <= 1'b0;
            pq_kvi_r    <= '0;
            req_ready_r <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_kv_r    <= '0;
        end else begin
            state_r     <= state_s;
            id_r        <= id_s;
            op_r        <= op_s;
            cnt_r       <= cnt_s;
            last_r      <= last_s;
            pq_enq_r    <= pq_enq_s;
            pq_deq_r    <= pq_deq_s;
            pq_rep_r    <= pq_rep_s;
            pq_kvi_r    <= pq_kvi_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_id_r    <= rsp_id_s;
            rsp_kv_r    <= rsp_kv_s;
        end
    end

    assign pq_enq     = pq_enq_r;
    assign pq_deq     = pq_deq_r;
    assign pq_replace = pq_rep_r;
    assign pq_kvi     = pq_kvi_r;
    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_kv     = rsp_kv_r;

`ifdef PQ_ARB_STATS_EN
    logic [15:0] stat_ops_r;
    logic [15:0] stat_blk_r;
    logic        blocked_s;

    assign blocked_s = (state_r == ARB) && (|req_valid) && !grant_found_s;

    // Saturating op and blocked-cycle counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_ops_r <= 16'h0000;
            stat_blk_r <= 16'h0000;
        end else begin
            if ((state_r == ISSUE) && (stat_ops_r != 16'hFFFF)) begin
                stat_ops_r <= stat_ops_r + 16'd1;
            end
            if (blocked_s && (stat_blk_r != 16'hFFFF)) begin
                stat_blk_r <= stat_blk_r + 16'd1;
            end
        end
    end

    assign stat_ops = stat_ops_r;
    assign stat_blk = stat_blk_r;
`else
    assign stat_ops = 16'h0000;
    assign stat_blk = 16'h0000;
`endif

endmodule

// File: tb/tb_pq_arb.sv
// Self-checking bench for pq_arb: directed scenarios plus random requests checked
// against a transaction-level model of arbitration and a behavioural sorted-queue PQ.
module tb_pq_arb;
    localparam int NREQ = 4;
    localparam int S    = 3;
    localparam int KW   = 8;
    localparam int VW   = 8;
    localparam int KVW  = KW + VW;
    localparam int CAP  = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*2-1:0]       req_op;
    logic [NREQ*KVW-1:0]     req_kv;
    logic [NREQ-1:0]         req_ready;
    logic                    rsp_valid;
    logic [1:0]              rsp_id;
    logic [KVW-1:0]          rsp_kv;
    logic [KVW-1:0]          pq_kvi;
    logic                    pq_enq, pq_deq, pq_replace;
    logic [KVW-1:0]          pq_kvo = '0;
    logic                    pq_empty = 1'b1;
    logic                    pq_full = 1'b0;
    logic [15:0]             stat_ops, stat_blk;

    int checks = 0;
    int failures = 0;

    // Requester intent and reference model state.
    bit             pv[NREQ];
    logic [1:0]     po[NREQ];
    logic [KVW-1:0] pk[NREQ];
    int             last_m = NREQ - 1;
    int             ops_m = 0;
    int             blk_m = 0;
    logic [KVW-1:0] pq_q[$];

    pq_arb #(.NREQ(NREQ), .SETTLE_CYC(S), .KW(KW), .VW(VW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_kv(req_kv),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_kv(rsp_kv),
        .pq_kvi(pq_kvi), .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_replace(pq_replace),
        .pq_kvo(pq_kvo), .pq_empty(pq_empty), .pq_full(pq_full),
        .stat_ops(stat_ops), .stat_blk(stat_blk)
    );

    always #5 clk = ~clk;

    task automatic pq_insert(input logic [KVW-1:0] kv);
        int pos;
        pos = pq_q.size();
        for (int i = pq_q.size() - 1; i >= 0; i--) begin
            if (pq_q[i][KVW-1:VW] > kv[KVW-1:VW]) pos = i;
        end
        pq_q.insert(pos, kv);
    endtask

    // Behavioural min-key priority queue acting on the arbiter's strobes.
    always @(posedge clk) begin
        if (pq_enq && pq_q.size() < CAP) pq_insert(pq_kvi);
        else if (pq_deq && pq_q.size() > 0) void'(pq_q.pop_front());
        else if (pq_replace && pq_q.size() > 0) begin
            void'(pq_q.pop_front());
            pq_insert(pq_kvi);
        end
        pq_kvo   <= (pq_q.size() > 0) ? pq_q[0] : '0;
        pq_empty <= (pq_q.size() == 0);
        pq_full  <= (pq_q.size() >= CAP);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive();
        for (int r = 0; r < NREQ; r++) begin
            req_valid[r]          = pv[r];
            req_op[2*r +: 2]      = po[r];
            req_kv[KVW*r +: KVW]  = pk[r];
        end
    endtask

    function automatic bit elig(input int r);
        if (!pv[r]) return 1'b0;
        case (po[r])
            2'b01:        return pq_q.size() < CAP;
            2'b10, 2'b11: return pq_q.size() > 0;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic int pick();
        int r;
        for (int k = 1; k <= NREQ; k++) begin
            r = (last_m + k) % NREQ;
            if (elig(r)) return r;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int r = 0; r < NREQ; r++) if (pv[r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk_stats();
`ifdef PQ_ARB_STATS_EN
        chk("stat_ops", stat_ops, ops_m);
        chk("stat_blk", stat_blk, blk_m);
`else
        chk("stat_ops", stat_ops, 32'd0);
        chk("stat_blk", stat_blk, 32'd0);
`endif
    endtask

    // One ARB decision; exp_w: directed winner, -1 directed block, -2 model only.
    task automatic round(input int exp_w);
        int w;
        int op;
        logic [KVW-1:0] head;
        w = pick();
        drive();
        if (w < 0) begin
            if (any_pend()) blk_m++;
            step();
            chk("blk_ready", req_ready, 32'd0);
            chk("blk_strobe", {pq_enq, pq_deq, pq_replace}, 32'd0);
            if (exp_w >= 0) chk("dir_grant", req_ready, 32'd1 << exp_w);
            chk_stats();
            return;
        end
        op   = int'(po[w]);
        head = (pq_q.size() > 0) ? pq_q[0] : '0;
        step();
        ops_m++;
        chk("ready", req_ready, 32'd1 << w);
        if (exp_w != -2) chk("dir_grant", req_ready, (exp_w < 0) ? 32'd0 : (32'd1 << exp_w));
        chk("strobe", {pq_enq, pq_deq, pq_replace}, {(op == 1), (op == 2), (op == 3)});
        chk("kvi", pq_kvi, pk[w]);
        chk("issue_rsp", rsp_valid, 32'd0);
        pv[w] = 1'b0;
        drive();
        for (int c = 0; c < S - 1; c++) begin
            step();
            chk("settle_strobe", {pq_enq, pq_deq, pq_replace}, 32'd0);
            chk("settle_ready", req_ready, 32'd0);
            chk("settle_rsp", rsp_valid, 32'd0);
        end
        step();
        chk("rsp_valid", rsp_valid, (op != 1));
        if (op != 1) begin
            chk("rsp_id", rsp_id, w);
            chk("rsp_kv", rsp_kv, head);
        end
        chk("resp_strobe", {pq_enq, pq_deq, pq_replace}, 32'd0);
        last_m = w;
        step();
        chk("arb_rsp", rsp_valid, 32'd0);
        chk_stats();
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [KVW-1:0] kv);
        pv[r] = 1'b1;
        po[r] = op;
        pk[r] = kv;
    endtask

    task automatic gen();
        for (int r = 0; r < NREQ; r++) begin
            if (!pv[r]) begin
                if ($urandom_range(0, 2) == 0) set_req(r, 2'($urandom_range(0, 3)), KVW'($urandom));
            end else if (po[r] == 2'b00 || $urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 0) pv[r] = 1'b0;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, 32'd0);
        chk({tag, "_strobe"}, {pq_enq, pq_deq, pq_replace}, 32'd0);
        chk({tag, "_rsp_valid"}, rsp_valid, 32'd0);
        chk({tag, "_rsp_id"}, rsp_id, 32'd0);
        chk({tag, "_rsp_kv"}, rsp_kv, 32'd0);
        chk({tag, "_kvi"}, pq_kvi, 32'd0);
        chk({tag, "_stat_ops"}, stat_ops, 32'd0);
        chk({tag, "_stat_blk"}, stat_blk, 32'd0);
    endtask

    initial begin
        for (int r = 0; r < NREQ; r++) begin
            pv[r] = 1'b0;
            po[r] = 2'b00;
            pk[r] = '0;
        end
        drive();
        // Reset state.
        rst = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b1;

        // Single ENQ {8,14} from req0.
        set_req(0, 2'b01, 16'h080E);
        round(0);

        // Round-robin fairness with all four holding ENQ.
        for (int n = 0; n < 5; n++) begin
            for (int r = 0; r < NREQ; r++) if (!pv[r]) set_req(r, 2'b01, KVW'($urandom));
            round((n + 1) % NREQ);
        end
        for (int r = 0; r < NREQ; r++) pv[r] = 1'b0;

        // Drain, then DEQ on empty blocks until an ENQ arrives.
        while (pq_q.size() > 0) begin
            set_req(1, 2'b10, 16'h0000);
            round(1);
        end
        set_req(1, 2'b10, 16'h0000);
        for (int n = 0; n < 3; n++) round(-1);
        set_req(0, 2'b01, 16'h0101);
        round(0);
        round(1);

        // REPLACE returns the old head {9,9}.
        set_req(0, 2'b01, 16'h0A0A);
        round(0);
        set_req(0, 2'b01, 16'h0909);
        round(0);
        set_req(2, 2'b11, 16'h1717);
        round(2);

        // Full PQ blocks ENQ but not DEQ.
        while (pq_q.size() < CAP) begin
            set_req(0, 2'b01, KVW'($urandom));
            round(0);
        end
        set_req(0, 2'b01, 16'h0505);
        round(-1);
        round(-1);
        set_req(3, 2'b10, 16'h0000);
        round(3);
        round(0);

        // Reset during SETTLE aborts the response and restores requester-0 priority.
        set_req(0, 2'b10, 16'h0000);
        round(0);
        set_req(1, 2'b10, 16'h0000);
        drive();
        step();
        chk("abort_ready", req_ready, 32'd2);
        pv[1] = 1'b0;
        drive();
        step();
        rst = 1'b0;
        step();
        chk_reset_outputs("abort");
        rst = 1'b1;
        last_m = NREQ - 1;
        ops_m  = 0;
        blk_m  = 0;
        step();
        chk("abort_no_rsp", rsp_valid, 32'd0);
        set_req(0, 2'b01, 16'h0202);
        set_req(2, 2'b01, 16'h0303);
        round(0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            gen();
            round(-2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
